// File: rtl/vreg_group_wb_collector.sv
// Tracks issued register-group writes and checks that write-back beats arrive in ascending register order.
// Latency: done/err pulse one cycle after the accepting beat edge; a new group becomes active one cycle after push.
// Backpressure: grp_ready drops while the group queue is full; wb_ready is low whenever no group is active.
module vreg_group_wb_collector #(
    parameter int ADDR_WIDTH = 5,
    parameter int QDEPTH     = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      grp_valid,
    output logic                      grp_ready,
    input  logic [ADDR_WIDTH-1:0]     grp_addr,
    input  logic [2:0]                grp_vlmul,
    input  logic                      wb_valid,
    output logic                      wb_ready,
    input  logic [ADDR_WIDTH-1:0]     wb_addr,
    output logic                      done,
    output logic                      err,
    output logic [ADDR_WIDTH-1:0]     done_addr,
    output logic [ADDR_WIDTH-1:0]     err_addr,
    output logic [$clog2(QDEPTH):0]   outstanding,
    output logic                      idle
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    // Group queue storage: first and last physical register of each group.
    logic [ADDR_WIDTH-1:0] base_mem [QDEPTH];
    logic [ADDR_WIDTH-1:0] last_mem [QDEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         rd_nxt;
    logic [CW-1:0]         count;

    state_t                state;
    logic [ADDR_WIDTH-1:0] expected;

    logic [ADDR_WIDTH-1:0] push_base;
    logic [ADDR_WIDTH-1:0] push_last;
    logic [ADDR_WIDTH-1:0] head_base;
    logic [ADDR_WIDTH-1:0] head_last;
    logic [ADDR_WIDTH-1:0] next_head_base;
    logic                  push;
    logic                  wb_fire;
    logic                  beat_ok;
    logic                  pop;

    // Expand the instruction's group address into a physical register range.
    // Integer LMUL scales the address and spans 2^vlmul registers; fractional LMUL is one register.
    always_comb begin
        push_base = grp_addr;
        push_last = grp_addr;
        if (!grp_vlmul[2]) begin
            push_base = grp_addr << grp_vlmul[1:0];
            push_last = push_base + ~({ADDR_WIDTH{1'b1}} << grp_vlmul[1:0]);
        end
    end

    assign grp_ready = (count != CW'(QDEPTH));
    assign wb_ready  = (state == S_ACTIVE);
    assign push      = grp_valid & grp_ready;
    assign wb_fire   = wb_valid & wb_ready;

    assign rd_nxt    = rd_ptr + 1'b1;
    assign head_base = base_mem[rd_ptr];
    assign head_last = last_mem[rd_ptr];
    assign beat_ok   = (wb_addr == expected);
    // A head leaves the queue on its final in-order beat or on any out-of-order beat.
    assign pop       = wb_fire & (~beat_ok | (expected == head_last));

    // With a single entry left, the successor head is the group being pushed this cycle,
    // which is not yet in storage; forward it so the next group starts without a bubble.
    assign next_head_base = (count == CW'(1)) ? push_base : base_mem[rd_nxt];

    assign outstanding = count;
    assign idle        = (count == '0);

    // Queue storage write; contents are only read while the matching entry is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            base_mem[wr_ptr] <= push_base;
            last_mem[wr_ptr] <= push_last;
        end
    end

    // Queue pointers and occupancy; push and pop in one cycle leave the count unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_nxt;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Head-group FSM: tracks the next register the head group must see.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            expected <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (push) begin
                        state    <= S_ACTIVE;
                        expected <= push_base;
                    end
                end
                S_ACTIVE: begin
                    if (pop) begin
                        if ((count == CW'(1)) && !push) begin
                            state <= S_IDLE;
                        end else begin
                            expected <= next_head_base;
                        end
                    end else if (wb_fire) begin
                        expected <= expected + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Completion/abort pulses and their sticky address reports.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done      <= 1'b0;
            err       <= 1'b0;
            done_addr <= '0;
            err_addr  <= '0;
        end else begin
            done <= pop & beat_ok;
            err  <= pop & ~beat_ok;
            if (pop) begin
                done_addr <= head_base;
            end
            if (pop && !beat_ok) begin
                err_addr <= wb_addr;
            end
        end
    end

endmodule

// File: tb/tb_vreg_group_wb_collector.sv
module tb_vreg_group_wb_collector;

    logic       clk = 1'b0;
    logic       rst;
    logic       grp_valid;
    logic       grp_ready;
    logic [4:0] grp_addr;
    logic [2:0] grp_vlmul;
    logic       wb_valid;
    logic       wb_ready;
    logic [4:0] wb_addr;
    logic       done;
    logic       err;
    logic [4:0] done_addr;
    logic [4:0] err_addr;
    logic [1:0] outstanding;
    logic       idle;

    vreg_group_wb_collector #(.ADDR_WIDTH(5), .QDEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .grp_valid(grp_valid), .grp_ready(grp_ready),
        .grp_addr(grp_addr), .grp_vlmul(grp_vlmul),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr),
        .done(done), .err(err), .done_addr(done_addr), .err_addr(err_addr),
        .outstanding(outstanding), .idle(idle)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Expected pulse: cycle stamp of the accepting edge, kind and addresses.
    typedef struct {
        int         cyc;
        bit         is_err;
        logic [4:0] da;
        logic [4:0] ea;
    } exp_t;
    exp_t sb[$];

    // Table of group expansions: hand-computed first/last physical register.
    typedef struct {
        logic [4:0] addr;
        logic [2:0] vlmul;
        logic [4:0] base;
        logic [4:0] last;
    } vec_t;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: wait bound expired (t=%0t)", nm, $time);
    endtask

    // Scoreboard monitor: every done/err pulse must match the expectation due this cycle.
    always @(negedge clk) begin
        if (rst) begin
            if (sb.size() > 0 && sb[0].cyc < cyc) begin
                n_chk++;
                n_fail++;
                $display("FAIL pulse_missing: due cycle %0d, none by cycle %0d", sb[0].cyc, cyc);
                void'(sb.pop_front());
            end
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                exp_t e;
                e = sb.pop_front();
                chk("pulse_done", int'(done), e.is_err ? 0 : 1);
                chk("pulse_err", int'(err), e.is_err ? 1 : 0);
                chk("done_addr", int'(done_addr), int'(e.da));
                if (e.is_err) chk("err_addr", int'(err_addr), int'(e.ea));
            end else if (done || err) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_pulse: done=%0d err=%0d done_addr=%0d at cycle %0d",
                         done, err, done_addr, cyc);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the group was accepted.
    task automatic push_grp(input logic [4:0] a, input logic [2:0] v);
        int t;
        grp_valid = 1'b1;
        grp_addr  = a;
        grp_vlmul = v;
        t = 0;
        while (!grp_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!grp_ready) fail_now("grp_ready_timeout");
        @(negedge clk);
        grp_valid = 1'b0;
    endtask

    // kind: 0 = no pulse, 1 = done expected, 2 = err expected.
    task automatic send_beat(input logic [4:0] a, input int kind, input logic [4:0] da,
                             input logic [4:0] ea);
        int t;
        exp_t e;
        wb_valid = 1'b1;
        wb_addr  = a;
        t = 0;
        while (!wb_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!wb_ready) fail_now("wb_ready_timeout");
        if (kind != 0) begin
            e.cyc    = cyc + 1;
            e.is_err = (kind == 2);
            e.da     = da;
            e.ea     = ea;
            sb.push_back(e);
        end
        @(negedge clk);
        wb_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[12];
        vt[0]  = '{5'd2,  3'd2, 5'd8,  5'd11};
        vt[1]  = '{5'd3,  3'd5, 5'd3,  5'd3};
        vt[2]  = '{5'd5,  3'd3, 5'd8,  5'd15};
        vt[3]  = '{5'd1,  3'd0, 5'd1,  5'd1};
        vt[4]  = '{5'd15, 3'd1, 5'd30, 5'd31};
        vt[5]  = '{5'd9,  3'd2, 5'd4,  5'd7};
        vt[6]  = '{5'd31, 3'd7, 5'd31, 5'd31};
        vt[7]  = '{5'd7,  3'd3, 5'd24, 5'd31};
        vt[8]  = '{5'd31, 3'd3, 5'd24, 5'd31};
        vt[9]  = '{5'd31, 3'd2, 5'd28, 5'd31};
        vt[10] = '{5'd1,  3'd4, 5'd1,  5'd1};
        vt[11] = '{5'd16, 3'd1, 5'd0,  5'd1};

        rst = 1'b0;
        grp_valid = 1'b0; grp_addr = '0; grp_vlmul = '0;
        wb_valid = 1'b0;  wb_addr = '0;
        repeat (2) @(negedge clk);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_done_addr", int'(done_addr), 0);
        chk("rst_err_addr", int'(err_addr), 0);
        chk("rst_outstanding", int'(outstanding), 0);
        chk("rst_idle", int'(idle), 1);
        chk("rst_grp_ready", int'(grp_ready), 1);
        chk("rst_wb_ready", int'(wb_ready), 0);
        rst = 1'b1;
        @(negedge clk);

        // Table: one group at a time, in-order beats, done with the hand-computed base.
        for (int i = 0; i < 12; i++) begin
            logic [4:0] a;
            int n;
            push_grp(vt[i].addr, vt[i].vlmul);
            chk("tbl_outstanding_1", int'(outstanding), 1);
            n = int'(5'(vt[i].last - vt[i].base)) + 1;
            a = vt[i].base;
            for (int k = 0; k < n; k++) begin
                send_beat(a, (k == n - 1) ? 1 : 0, vt[i].base, 5'd0);
                a = a + 5'd1;
            end
            chk("tbl_idle_after", int'(idle), 1);
            chk("tbl_wb_ready_after", int'(wb_ready), 0);
        end

        // Two queued groups: full queue blocks a third, heads chain without a gap.
        push_grp(5'd1, 3'd1);
        push_grp(5'd7, 3'd0);
        grp_valid = 1'b1; grp_addr = 5'd0; grp_vlmul = 3'd0;
        chk("full_grp_ready", int'(grp_ready), 0);
        chk("full_outstanding", int'(outstanding), 2);
        @(negedge clk);
        chk("full_grp_ready_hold", int'(grp_ready), 0);
        grp_valid = 1'b0;
        send_beat(5'd2, 0, 5'd0, 5'd0);
        send_beat(5'd3, 1, 5'd2, 5'd0);
        chk("chain_wb_ready", int'(wb_ready), 1);
        chk("chain_outstanding", int'(outstanding), 1);
        send_beat(5'd7, 1, 5'd7, 5'd0);
        chk("chain_idle", int'(idle), 1);

        // Out-of-order beat aborts the group; later beats stall with nothing queued.
        push_grp(5'd1, 3'd2);
        send_beat(5'd4, 0, 5'd0, 5'd0);
        send_beat(5'd6, 2, 5'd4, 5'd6);
        chk("abort_outstanding", int'(outstanding), 0);
        chk("abort_idle", int'(idle), 1);
        wb_valid = 1'b1; wb_addr = 5'd5;
        @(negedge clk);
        chk("abort_stall_1", int'(wb_ready), 0);
        @(negedge clk);
        chk("abort_stall_2", int'(wb_ready), 0);
        wb_valid = 1'b0;

        // Wrap from 31 to 0 across two queued groups.
        push_grp(5'd15, 3'd1);
        push_grp(5'd0, 3'd3);
        send_beat(5'd30, 0, 5'd0, 5'd0);
        send_beat(5'd31, 1, 5'd30, 5'd0);
        for (int k = 0; k < 8; k++) begin
            send_beat(5'(k), (k == 7) ? 1 : 0, 5'd0, 5'd0);
        end
        chk("wrap_idle", int'(idle), 1);

        // Push into an empty queue together with a beat: beat waits one cycle.
        chk("pe_wb_ready_pre", int'(wb_ready), 0);
        fork
            push_grp(5'd12, 3'd0);
            send_beat(5'd12, 1, 5'd12, 5'd0);
        join
        chk("pe_idle", int'(idle), 1);

        // Final beat of a single-entry queue coincides with a push: new head has no bubble.
        push_grp(5'd10, 3'd0);
        fork
            push_grp(5'd11, 3'd0);
            send_beat(5'd10, 1, 5'd10, 5'd0);
        join
        chk("pp_outstanding", int'(outstanding), 1);
        chk("pp_wb_ready", int'(wb_ready), 1);
        send_beat(5'd11, 1, 5'd11, 5'd0);
        chk("pp_idle", int'(idle), 1);

        // Reset mid-group: outputs clear immediately, no stale pulses afterwards.
        push_grp(5'd0, 3'd3);
        send_beat(5'd0, 0, 5'd0, 5'd0);
        send_beat(5'd1, 0, 5'd0, 5'd0);
        send_beat(5'd2, 0, 5'd0, 5'd0);
        chk("mid_outstanding", int'(outstanding), 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_outstanding", int'(outstanding), 0);
        chk("arst_idle", int'(idle), 1);
        chk("arst_wb_ready", int'(wb_ready), 0);
        chk("arst_grp_ready", int'(grp_ready), 1);
        chk("arst_done_addr", int'(done_addr), 0);
        chk("arst_err_addr", int'(err_addr), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_err", int'(err), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        push_grp(5'd4, 3'd1);
        send_beat(5'd8, 0, 5'd0, 5'd0);
        send_beat(5'd9, 1, 5'd8, 5'd0);
        chk("post_rst_idle", int'(idle), 1);

        repeat (4) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vreg_group_wb_collector.md
Name: vreg_group_wb_collector

Overview:
- Write-back side counterpart to the register-group address generator.
- Queues issued register-group writes as (base address, vlmul) pairs. Checks that per-register write-back beats from the lane pipeline arrive in strict ascending register order. Signals completion or error for each group.
- Sits between the vector issue stage and the register-file write port. Provides group-level completion to the scoreboard.

Parameters:
- ADDR_WIDTH, 5, width of vector register addresses (32 registers).
- QDEPTH, 2, number of outstanding groups held (power of two, ≥2).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- grp_valid  in  1  issue stage offers a group.
- grp_ready  out  1  group queue can accept.
- grp_addr  in  ADDR_WIDTH  register-group address as written in the instruction.
- grp_vlmul  in  3  vlmul encoding of the group.
- wb_valid  in  1  write-back beat present.
- wb_ready  out  1  collector accepts the beat.
- wb_addr  in  ADDR_WIDTH  physical register written by the beat.
- done  out  1  one-cycle pulse: head group completed.
- err  out  1  one-cycle pulse: head group aborted on out-of-order beat.
- done_addr  out  ADDR_WIDTH  base physical register of the completed or aborted group; valid when done|err.
- err_addr  out  ADDR_WIDTH  offending wb_addr; valid when err.
- outstanding  out  $clog2(QDEPTH)+1  number of queued groups, including the head.
- idle  out  1  high when outstanding==0.

Behaviour:
- Group expansion, computed at push:
  - vlmul<4: base = (grp_addr<<vlmul) truncated to ADDR_WIDTH; last = base + (1<<vlmul) − 1, mod 2^ADDR_WIDTH.
  - vlmul≥4 (fractional): base = last = grp_addr, a single register.
- Queue:
  - Circular FIFO of {base,last}, depth QDEPTH.
  - grp_ready = (outstanding != QDEPTH), registered count only. When full, a pop in the same cycle does not open the slot until the next cycle.
  - Push on grp_valid & grp_ready.
- FSM, 2 states:
  - IDLE: queue empty.
  - ACTIVE: head loaded. Register `expected` holds the next required address.
  - IDLE→ACTIVE on the cycle after a push into an empty queue. expected = pushed base.
  - ACTIVE→ACTIVE on pop with the queue still non-empty. expected = the new head's base, with no bubble.
  - ACTIVE→IDLE on pop of the last entry.
- wb_ready = (state==ACTIVE). Beats offered in IDLE are not accepted and stay stalled.
- Accepted beat with wb_addr==expected:
  - If expected==last: pop head; next cycle done=1, done_addr=head base.
  - Otherwise expected <= expected+1, mod 2^ADDR_WIDTH, so wrap from 31 to 0 is legal.
- Accepted beat with wb_addr!=expected:
  - Pop head (group aborted).
  - Next cycle err=1, done=0, done_addr=head base, err_addr=wb_addr.
- Latency: done/err are asserted exactly 1 cycle after the accepting edge. At most one beat per cycle; back-to-back beats are accepted every cycle.
- Simultaneous push and pop: both take effect; outstanding is unchanged.
- Simultaneous push into an empty queue and wb_valid in the same cycle: the beat is not accepted that cycle (wb_ready=0).
- Reset values, async while rst=0: queue empty, pointers 0, state IDLE, expected 0, done=0, err=0, done_addr=0, err_addr=0, outstanding=0, idle=1, grp_ready=1, wb_ready=0.
- Reset mid-group discards all queued groups. No done/err is produced for them.
- done_addr/err_addr hold their last value between pulses.

Test Plan:
1. grp_addr=2, vlmul=2 (base 8); beats 8,9,10,11 back-to-back -> done pulse in the cycle after beat 11 accepted, done_addr=8, idle=1 next cycle.
2. grp_addr=3, vlmul=5 (fractional); beat 3 -> done after 1 beat, done_addr=3. Then grp_addr=5, vlmul=3 (base 40 mod 32 = 8) -> expects 8..15, done_addr=8.
3. Two groups pushed: vlmul=1 addr=1 (regs 2,3) and vlmul=0 addr=7 (reg 7); then grp_valid again -> grp_ready=0 while outstanding=2. Beats 2,3,7 -> two done pulses with done_addr 2 then 7; no idle cycle between groups.
4. Group vlmul=2 addr=1 (regs 4–7); beats 4,6 -> err pulse on the cycle after 6 accepted, done_addr=4, err_addr=6, done=0, queue popped.
5. Group base 30 with vlmul=1 (grp_addr=15 → 30, last 31), then group base 0 with vlmul=3 (last 7). Beats 30,31,0..7 -> two done pulses, no err; wrap handled.
6. Group vlmul=3 addr=0 with 3 beats accepted; assert rst low mid-group -> all outputs at reset values immediately. After release, a new group completes normally with no stale done or err.
